word_guess_engine: RTL and testbench

- Parametrised letter-guessing game core on active-low 7-segment glyphs; successor to the fixed 4-letter, 16-word game controller.
- Adds a runtime-loadable word bank, configurable word length, all-position reveal per guess, miss limit, hint budget and a countdown driven by an external 1 Hz tick.
- Sits between the glyph-entry logic (switches to guess_seg), a random index source, the seconds tick generator, and the HEX display drivers.

---
 rtl/word_guess_engine.sv | 154 +++++++++++++++
 tb/tb_word_guess_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/word_guess_engine.sv
// Letter-guessing game core: loadable word bank, per-guess reveal, miss/hint/time limits.
// Optional `SCORE_EN adds a saturating score output accumulated on each win.
module word_guess_engine #(
    parameter int NUM_CHARS  = 4,
    parameter int WORD_DEPTH = 16,
    parameter int IDX_W      = 4,
    parameter int MAX_HINTS  = 1,
    parameter int MAX_MISSES = 6,
    parameter int TIME_LIMIT = 60
) (
    input  logic                   clk2,
    input  logic                   rst,
    input  logic                   word_we,
    input  logic [IDX_W-1:0]       word_waddr,
    input  logic [NUM_CHARS*7-1:0] word_wdata,
    input  logic [IDX_W-1:0]       rand_idx,
    input  logic                   start,
    input  logic                   guess_valid,
    input  logic [6:0]             guess_seg,
    input  logic                   hint_req,
    input  logic                   sec_tick,
    output logic [NUM_CHARS*7-1:0] disp,
    output logic [NUM_CHARS-1:0]   revealed,
    output logic [2:0]             hints_left,
    output logic [3:0]             misses,
    output logic [7:0]             time_left,
    output logic                   busy,
    output logic                   win,
    output logic                   lose
`ifdef SCORE_EN
    ,
    output logic [9:0]             score
`endif
);

    localparam int W = NUM_CHARS * 7;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_UNDER = 7'b1110111;

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, WIN, LOSE} state_t;

    state_t               state, state_nx;
    logic [W-1:0]         bank [WORD_DEPTH];
    logic [W-1:0]         cur_word;
    logic                 hint_q;
    logic [NUM_CHARS-1:0] guess_mask, hint_pick, hint_mask, rev_nx;
    logic                 hint_fire, miss;
    logic [3:0]           misses_nx;
    logic [2:0]           hints_nx;
    logic [7:0]           time_nx;

    // NOTE: the bank has no reset on purpose; it maps onto RAM and keeps its words across rst.
    always_ff @(posedge clk2) begin
        if (word_we)
            bank[word_waddr] <= word_wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk2) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        guess_mask = '0;
        hint_pick  = '0;
        for (int i = 0; i < NUM_CHARS; i++)
            guess_mask[i] = guess_valid && (cur_word[7*i +: 7] == guess_seg);
        // Leftmost unrevealed char wins, judged on the mask before this cycle's guess.
        for (int i = NUM_CHARS - 1; i >= 0; i--)
            if (!revealed[i] && hint_pick == '0)
                hint_pick[i] = 1'b1;
        hint_fire = hint_req && !hint_q && (hints_left != 3'd0) && (hint_pick != '0);
        hint_mask = hint_fire ? hint_pick : '0;
        rev_nx    = revealed | guess_mask | hint_mask;
        miss      = guess_valid && ((guess_mask & ~revealed) == '0);
        misses_nx = (miss && misses != 4'd15) ? misses + 4'd1 : misses;
        hints_nx  = hint_fire ? hints_left - 3'd1 : hints_left;
        time_nx   = (sec_tick && time_left != 8'd0) ? time_left - 8'd1 : time_left;

        state_nx = state;
        case (state)
            IDLE:      if (start) state_nx = LOAD;
            LOAD:      state_nx = PLAY;
            PLAY: begin
                if (&rev_nx)                          state_nx = WIN;
                else if (misses_nx == 4'(MAX_MISSES)) state_nx = LOSE;
                else if (time_nx == 8'd0)             state_nx = LOSE;
            end
            WIN, LOSE: if (start) state_nx = LOAD;
            default:   state_nx = IDLE;
        endcase
    end

`ifdef SCORE_EN
    logic [10:0] score_sum;
    assign score_sum = {1'b0, score} + {3'b0, time_nx} + {5'b0, hints_nx, 3'b0};
`endif

    always_ff @(posedge clk2) begin
        if (!rst) begin
            revealed   <= '0;
            hints_left <= 3'(MAX_HINTS);
            misses     <= '0;
            time_left  <= 8'(TIME_LIMIT);
            win        <= 1'b0;
            lose       <= 1'b0;
            hint_q     <= 1'b0;
`ifdef SCORE_EN
            score      <= '0;
`endif
        end else begin
            hint_q <= hint_req;
            case (state)
                LOAD: begin
                    cur_word   <= bank[rand_idx];
                    revealed   <= '0;
                    misses     <= '0;
                    hints_left <= 3'(MAX_HINTS);
                    time_left  <= 8'(TIME_LIMIT);
                    win        <= 1'b0;
                    lose       <= 1'b0;
                end
                PLAY: begin
                    revealed   <= (state_nx == LOSE) ? '1 : rev_nx;
                    misses     <= misses_nx;
                    hints_left <= hints_nx;
                    time_left  <= time_nx;
                    win        <= (state_nx == WIN);
                    lose       <= (state_nx == LOSE);
`ifdef SCORE_EN
                    if (state_nx == WIN)
                        score <= (score_sum > 11'd1023) ? 10'd1023 : score_sum[9:0];
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == PLAY);

    always_comb begin
        disp = '1;
        for (int i = 0; i < NUM_CHARS; i++) begin
            if (state == PLAY || state == WIN || state == LOSE)
                disp[7*i +: 7] = revealed[i] ? cur_word[7*i +: 7] : GLYPH_UNDER;
            else
                disp[7*i +: 7] = GLYPH_BLANK;
        end
    end

endmodule

// File: tb/tb_word_guess_engine.sv
// Bench for word_guess_engine: directed game scenarios plus randomized play against a
// rule-level model of the game kept here.
module tb_word_guess_engine;

    localparam int NC = 4, DEPTH = 16, IW = 4, MAXH = 1, MAXM = 6, TL = 60;
    localparam logic [6:0] BLANK = 7'b1111111, UNDER = 7'b1110111;
    localparam logic [6:0] G_M = 7'b0000110, G_O = 7'b1000000, G_N = 7'b1001000;
    localparam logic [NC*7-1:0] MOON = {G_M, G_O, G_O, G_N};
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_PLAY = 2, PH_WON = 3, PH_LOST = 4;

    logic clk2 = 1'b0, rst = 1'b0, word_we = 1'b0, start = 1'b0;
    logic guess_valid = 1'b0, hint_req = 1'b0, sec_tick = 1'b0;
    logic [IW-1:0] word_waddr = '0, rand_idx = '0;
    logic [NC*7-1:0] word_wdata = '0;
    logic [6:0] guess_seg = '0;
    logic [NC*7-1:0] disp;
    logic [NC-1:0] revealed;
    logic [2:0] hints_left;
    logic [3:0] misses;
    logic [7:0] time_left;
    logic busy, win, lose;
`ifdef SCORE_EN
    logic [9:0] score;
`endif

    word_guess_engine #(.NUM_CHARS(NC), .WORD_DEPTH(DEPTH), .IDX_W(IW), .MAX_HINTS(MAXH),
                        .MAX_MISSES(MAXM), .TIME_LIMIT(TL)) dut (
        .clk2(clk2), .rst(rst), .word_we(word_we), .word_waddr(word_waddr),
        .word_wdata(word_wdata), .rand_idx(rand_idx), .start(start),
        .guess_valid(guess_valid), .guess_seg(guess_seg), .hint_req(hint_req),
        .sec_tick(sec_tick), .disp(disp), .revealed(revealed), .hints_left(hints_left),
        .misses(misses), .time_left(time_left), .busy(busy), .win(win), .lose(lose)
`ifdef SCORE_EN
        , .score(score)
`endif
    );

    always #5 clk2 = ~clk2;

    int tests = 0, fails = 0;

    // Rule-level game model, advanced once per clock edge with the inputs presented to the DUT.
    logic [NC*7-1:0] m_bank [DEPTH];
    logic [6:0] m_word [NC];
    logic [NC-1:0] m_rev;
    int m_phase, m_miss, m_hints, m_time, m_score;
    bit m_win, m_lose, m_hint_prev;

    function automatic void model_edge();
        if (!rst) begin
            m_phase = PH_IDLE; m_rev = '0; m_miss = 0; m_hints = MAXH; m_time = TL;
            m_win = 0; m_lose = 0; m_score = 0;
        end else begin
            case (m_phase)
                PH_IDLE: if (start) m_phase = PH_LOAD;
                PH_LOAD: begin
                    for (int i = 0; i < NC; i++) m_word[i] = m_bank[rand_idx][7*i +: 7];
                    m_rev = '0; m_miss = 0; m_hints = MAXH; m_time = TL;
                    m_win = 0; m_lose = 0; m_phase = PH_PLAY;
                end
                PH_PLAY: begin
                    int pick = -1, fresh = 0, shown = 0;
                    bit use_hint;
                    for (int i = 0; i < NC; i++) if (!m_rev[i]) pick = i;
                    use_hint = hint_req && !m_hint_prev && m_hints > 0 && pick >= 0;
                    if (guess_valid) begin
                        for (int i = 0; i < NC; i++)
                            if (m_word[i] == guess_seg) begin
                                if (!m_rev[i]) fresh++;
                                m_rev[i] = 1'b1;
                            end
                        if (fresh == 0 && m_miss < 15) m_miss++;
                    end
                    if (use_hint) begin m_rev[pick] = 1'b1; m_hints--; end
                    if (sec_tick && m_time > 0) m_time--;
                    for (int i = 0; i < NC; i++) shown += int'(m_rev[i]);
                    if (shown == NC) begin
                        m_phase = PH_WON; m_win = 1;
                        m_score = m_score + m_time + 8 * m_hints;
                        if (m_score > 1023) m_score = 1023;
                    end else if (m_miss == MAXM || m_time == 0) begin
                        m_phase = PH_LOST; m_lose = 1; m_rev = '1;
                    end
                end
                default: if (start) m_phase = PH_LOAD;
            endcase
        end
        if (word_we) m_bank[word_waddr] = word_wdata;
        m_hint_prev = rst ? hint_req : 1'b0;
    endfunction

    function automatic logic [NC*7-1:0] model_disp();
        logic [NC*7-1:0] d;
        for (int i = 0; i < NC; i++)
            if (m_phase == PH_PLAY || m_phase == PH_WON || m_phase == PH_LOST)
                d[7*i +: 7] = m_rev[i] ? m_word[i] : UNDER;
            else
                d[7*i +: 7] = BLANK;
        return d;
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk2);
        #1;
        start = 0; guess_valid = 0; sec_tick = 0; word_we = 0;
    endtask

    task automatic start_round();
        rand_idx = 3; start = 1; step(); step();
    endtask

    task automatic guess(input logic [6:0] g);
        guess_valid = 1; guess_seg = g; step();
    endtask

    task automatic test_reset();
        rst = 0; step(); step();
        tests++; if (disp !== {NC{BLANK}}) begin fails++; $display("FAIL reset_disp got %h exp %h", disp, {NC{BLANK}}); end
        tests++; if ({revealed, misses, hints_left, time_left} !== {4'b0, 4'd0, 3'd1, 8'd60}) begin
            fails++; $display("FAIL reset_counters got rev=%b mis=%0d hint=%0d time=%0d", revealed, misses, hints_left, time_left); end
        tests++; if ({busy, win, lose} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {busy, win, lose}); end
        rst = 1;
    endtask

    task automatic test_guess();
        word_we = 1; word_waddr = 3; word_wdata = MOON; step();
        start_round();
        tests++; if (busy !== 1'b1 || disp !== {NC{UNDER}}) begin fails++; $display("FAIL play_entry got busy=%b disp=%h", busy, disp); end
        guess(G_O);
        tests++; if (revealed !== 4'b0110 || misses !== 4'd0) begin fails++; $display("FAIL guess_o got rev=%b mis=%0d exp 0110/0", revealed, misses); end
        tests++; if (disp !== {UNDER, G_O, G_O, UNDER}) begin fails++; $display("FAIL guess_o_disp got %h exp %h", disp, {UNDER, G_O, G_O, UNDER}); end
    endtask

    task automatic test_win();
        guess(G_M);
        tests++; if (revealed !== 4'b1110 || win !== 1'b0) begin fails++; $display("FAIL guess_m got rev=%b win=%b", revealed, win); end
        guess(G_N);
        tests++; if ({win, lose, busy} !== 3'b100 || disp !== MOON || revealed !== 4'b1111) begin
            fails++; $display("FAIL win got wlb=%b disp=%h rev=%b", {win, lose, busy}, disp, revealed); end
`ifdef SCORE_EN
        tests++; if (score !== 10'd68) begin fails++; $display("FAIL score_first got %0d exp 68", score); end
`endif
        guess(7'b0000000);
        tests++; if (misses !== 4'd0 || win !== 1'b1) begin fails++; $display("FAIL win_frozen got mis=%0d win=%b", misses, win); end
    endtask

    task automatic test_misses();
        start_round();
        for (int i = 1; i <= MAXM; i++) begin
            guess(7'b0000000);
            tests++; if (misses !== 4'(i) || lose !== (i == MAXM)) begin
                fails++; $display("FAIL miss_%0d got mis=%0d lose=%b", i, misses, lose); end
        end
        tests++; if (busy !== 1'b0 || revealed !== 4'b1111 || disp !== MOON) begin
            fails++; $display("FAIL lose_state got busy=%b rev=%b disp=%h", busy, revealed, disp); end
        guess(7'b0000000);
        tests++; if (misses !== 4'd6) begin fails++; $display("FAIL miss_7th got %0d exp 6", misses); end
    endtask

    task automatic test_hint();
        start_round();
        hint_req = 1;
        repeat (5) step();
        tests++; if (revealed !== 4'b1000 || hints_left !== 3'd0) begin fails++; $display("FAIL hint_one got rev=%b hints=%0d", revealed, hints_left); end
        tests++; if (disp !== {G_M, UNDER, UNDER, UNDER}) begin fails++; $display("FAIL hint_disp got %h", disp); end
        hint_req = 0; step(); hint_req = 1; step(); step(); hint_req = 0;
        tests++; if (revealed !== 4'b1000 || hints_left !== 3'd0) begin fails++; $display("FAIL hint_spent got rev=%b hints=%0d", revealed, hints_left); end
        guess(G_O); guess(G_N);
        tests++; if (win !== 1'b1) begin fails++; $display("FAIL hint_round_win got %b exp 1", win); end
    endtask

    task automatic test_timer();
        start_round();
        repeat (TL - 1) begin sec_tick = 1; step(); end
        tests++; if (time_left !== 8'd1 || busy !== 1'b1) begin fails++; $display("FAIL timer_59 got time=%0d busy=%b", time_left, busy); end
        sec_tick = 1; step();
        tests++; if (time_left !== 8'd0 || {win, lose, busy} !== 3'b010) begin
            fails++; $display("FAIL timer_out got time=%0d wlb=%b", time_left, {win, lose, busy}); end
        start_round();
        guess(G_O); guess(G_M);
        repeat (TL - 1) begin sec_tick = 1; step(); end
        sec_tick = 1; guess(G_N);
        tests++; if ({win, lose} !== 2'b10 || time_left !== 8'd0) begin
            fails++; $display("FAIL final_tick_win got wl=%b time=%0d", {win, lose}, time_left); end
`ifdef SCORE_EN
        tests++; if (score !== 10'd136) begin fails++; $display("FAIL score_accum got %0d exp 136", score); end
`endif
    endtask

    task automatic test_midreset();
        start_round(); guess(G_O);
        rst = 0; step();
        tests++; if (disp !== {NC{BLANK}} || {busy, win, lose} !== 3'b000 || revealed !== 4'b0) begin
            fails++; $display("FAIL midreset got disp=%h blw=%b rev=%b", disp, {busy, win, lose}, revealed); end
        tests++; if ({misses, hints_left, time_left} !== {4'd0, 3'd1, 8'd60}) begin
            fails++; $display("FAIL midreset_cnt got mis=%0d hint=%0d time=%0d", misses, hints_left, time_left); end
`ifdef SCORE_EN
        tests++; if (score !== 10'd0) begin fails++; $display("FAIL score_reset got %0d exp 0", score); end
`endif
        rst = 1;
        start_round(); guess(G_O);
        tests++; if (revealed !== 4'b0110) begin fails++; $display("FAIL bank_kept got rev=%b exp 0110", revealed); end
    endtask

    task automatic test_random();
        logic [6:0] alph [5];
        alph[0] = G_M; alph[1] = G_O; alph[2] = G_N; alph[3] = 7'b0001000; alph[4] = 7'b0010010;
        for (int a = 0; a < DEPTH; a++) begin
            word_we = 1; word_waddr = IW'(a);
            for (int c = 0; c < NC; c++) word_wdata[7*c +: 7] = alph[$urandom_range(0, 3)];
            step();
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 299) != 0);
            word_we = ($urandom_range(0, 7) == 0);
            word_waddr = IW'($urandom_range(0, DEPTH - 1));
            for (int c = 0; c < NC; c++) word_wdata[7*c +: 7] = alph[$urandom_range(0, 3)];
            rand_idx = IW'($urandom_range(0, DEPTH - 1));
            start = ($urandom_range(0, 19) == 0);
            guess_valid = ($urandom_range(0, 2) == 0);
            guess_seg = alph[$urandom_range(0, 4)];
            if ($urandom_range(0, 5) == 0) hint_req = ~hint_req;
            sec_tick = ($urandom_range(0, 3) == 0);
            step();
            tests++;
            if (disp !== model_disp() || revealed !== m_rev || hints_left !== 3'(m_hints) ||
                misses !== 4'(m_miss) || time_left !== 8'(m_time) || busy !== (m_phase == PH_PLAY) ||
                win !== m_win || lose !== m_lose) begin
                fails++;
                $display("FAIL random_%0d got disp=%h rev=%b h=%0d m=%0d t=%0d b=%b w=%b l=%b exp disp=%h rev=%b h=%0d m=%0d t=%0d b=%b w=%b l=%b",
                         cyc, disp, revealed, hints_left, misses, time_left, busy, win, lose,
                         model_disp(), m_rev, m_hints, m_miss, m_time, m_phase == PH_PLAY, m_win, m_lose);
            end
`ifdef SCORE_EN
            tests++; if (score !== 10'(m_score)) begin fails++; $display("FAIL random_score_%0d got %0d exp %0d", cyc, score, m_score); end
`endif
        end
        rst = 1;
    endtask

    initial begin
        test_reset();
        test_guess();
        test_win();
        test_misses();
        test_hint();
        test_timer();
        test_midreset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
